// File: rtl/cordic_pkg.sv
// Shared widths, sequencer state encoding and the quadrant constants used by
// the cordic datapath and its phase-sequencing front end.
package cordic_pkg;

    localparam int DEF_PHASE_W = 16;
    localparam int DEF_ACC_W   = 32;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } state_t;

    // Quadrant boundaries of a 16-bit binary-angle theta (full turn = 2^16).
    localparam logic [15:0] QUAD_0   = 16'h0000;
    localparam logic [15:0] QUAD_90  = 16'h4000;
    localparam logic [15:0] QUAD_180 = 16'h8000;
    localparam logic [15:0] QUAD_270 = 16'hC000;

endpackage

// File: rtl/cordic_phase_gen_phase_accum.sv
// NCO phase accumulator with a modulo offset adder; theta_next is the phase
// that the accumulator value after this edge will produce.
module phase_accum
    import cordic_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               clr,
    input  logic               step,
    input  logic [ACC_W-1:0]   fcw,
    input  logic [PHASE_W-1:0] offset,
    output logic [PHASE_W-1:0] theta_next
);

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_next_s;

    // Next accumulator value and the phase it maps to (both wrap naturally).
    always_comb begin
        acc_next_s = acc_r;
        if (clr) begin
            acc_next_s = '0;
        end else if (step) begin
            acc_next_s = acc_r + fcw;
        end else begin
            acc_next_s = acc_r;
        end
        theta_next = acc_next_s[ACC_W-1 -: PHASE_W] + offset;
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            acc_r <= '0;
        end else begin
            acc_r <= acc_next_s;
        end
    end

endmodule

// File: rtl/cordic_phase_gen.sv
// Burst sequencer that feeds the cordic one theta per transaction from an NCO
// phase accumulator, honouring cordic_ready and reporting burst completion.
module cordic_phase_gen
    import cordic_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               start,
    input  logic               stop,
    input  logic [ACC_W-1:0]   fcw,
    input  logic [PHASE_W-1:0] phase_offset,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic               cordic_ready,
    output logic [PHASE_W-1:0] theta,
    output logic               in_valid,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   sample_idx
);

    state_t             state_r;
    logic [ACC_W-1:0]   fcw_r;
    logic [PHASE_W-1:0] offset_r;
    logic [CNT_W-1:0]   num_r;

    logic               launch_s;
    logic               xfer_s;
    logic               step_s;
    logic [PHASE_W-1:0] offset_s;
    logic [PHASE_W-1:0] theta_next_s;
    logic [CNT_W-1:0]   idx_inc_s;

    // Handshake decode; the live offset is used only on the launch cycle.
    always_comb begin
        launch_s  = (state_r == IDLE) && start && !stop;
        xfer_s    = in_valid && cordic_ready;
        step_s    = (state_r == ISSUE) && xfer_s;
        idx_inc_s = sample_idx + {{(CNT_W-1){1'b0}}, 1'b1};
        if (state_r == IDLE) begin
            offset_s = phase_offset;
        end else begin
            offset_s = offset_r;
        end
    end

    phase_accum #(
        .PHASE_W (PHASE_W),
        .ACC_W   (ACC_W)
    ) u_accum (
        .clk        (clk),
        .rstb       (rstb),
        .clr        (launch_s),
        .step       (step_s),
        .fcw        (fcw_r),
        .offset     (offset_s),
        .theta_next (theta_next_s)
    );

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r    <= IDLE;
            fcw_r      <= '0;
            offset_r   <= '0;
            num_r      <= '0;
            theta      <= '0;
            in_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (launch_s) begin
                        fcw_r      <= fcw;
                        offset_r   <= phase_offset;
                        num_r      <= num_samples;
                        sample_idx <= '0;
                        busy       <= 1'b1;
                        theta      <= theta_next_s;
                        in_valid   <= 1'b1;
                        state_r    <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (xfer_s) begin
                        in_valid   <= 1'b0;
                        sample_idx <= idx_inc_s;
                        theta      <= theta_next_s;
                        if (stop) begin
                            busy    <= 1'b0;
                            state_r <= IDLE;
                        end else if ((num_r != '0) && (idx_inc_s == num_r)) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= IDLE;
                        end else begin
                            state_r <= WAIT_LOW;
                        end
                    end else if (stop) begin
                        in_valid <= 1'b0;
                        busy     <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                WAIT_LOW: begin
                    if (stop) begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else if (!cordic_ready) begin
                        state_r <= WAIT_HIGH;
                    end else begin
                        state_r <= WAIT_LOW;
                    end
                end
                WAIT_HIGH: begin
                    if (stop) begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else if (cordic_ready) begin
                        in_valid <= 1'b1;
                        state_r  <= ISSUE;
                    end else begin
                        state_r <= WAIT_HIGH;
                    end
                end
                default: begin
                    in_valid <= 1'b0;
                    busy     <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed bench for cordic_phase_gen: table-driven bursts plus hand-written
// backpressure, stop, continuous-mode and reset sequences.
module tb_cordic_phase_gen;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] fcw = 32'h0;
    logic [15:0] phase_offset = 16'h0;
    logic [15:0] num_samples = 16'h0;
    logic        cordic_ready = 1'b1;
    logic [15:0] theta;
    logic        in_valid;
    logic        busy;
    logic        done;
    logic [15:0] sample_idx;

    int total = 0;
    int bad = 0;

    int          ndone;
    bit          prev_x;
    logic [15:0] xq[$];

    typedef struct {
        logic [31:0]      fcw;
        logic [15:0]      off;
        logic [15:0]      num;
        int               n;
        logic [3:0][15:0] th;
    } vec_t;

    vec_t vecs[3];

    cordic_phase_gen dut (
        .clk          (clk),
        .rstb         (rstb),
        .start        (start),
        .stop         (stop),
        .fcw          (fcw),
        .phase_offset (phase_offset),
        .num_samples  (num_samples),
        .cordic_ready (cordic_ready),
        .theta        (theta),
        .in_valid     (in_valid),
        .busy         (busy),
        .done         (done),
        .sample_idx   (sample_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of a cordic that drops ready for one cycle after each transfer.
    task automatic cyc();
        if (done) ndone++;
        cordic_ready = prev_x ? 1'b0 : 1'b1;
        prev_x = 1'b0;
        if (in_valid && cordic_ready) begin
            xq.push_back(theta);
            prev_x = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic begin_burst(input logic [31:0] f, input logic [15:0] o, input logic [15:0] n);
        fcw = f; phase_offset = o; num_samples = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; prev_x = 1'b0; xq.delete();
    endtask

    initial begin
        vecs[0] = '{fcw: 32'h4000_0000, off: 16'h0000, num: 16'd4, n: 4,
                    th: {16'hC000, 16'h8000, 16'h4000, 16'h0000}};
        vecs[1] = '{fcw: 32'h8000_0000, off: 16'h9000, num: 16'd3, n: 3,
                    th: {16'h0000, 16'h9000, 16'h1000, 16'h9000}};
        vecs[2] = '{fcw: 32'h0123_4567, off: 16'h1111, num: 16'd2, n: 2,
                    th: {16'h0000, 16'h0000, 16'h1234, 16'h1111}};

        repeat (2) @(negedge clk);
        chk("reset_in_valid", {31'b0, in_valid}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_theta", {16'b0, theta}, 32'd0);
        rstb = 1'b1;
        @(negedge clk);

        // start with stop in the same cycle must not launch
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("start_stop_busy", {31'b0, busy}, 32'd0);
        chk("start_stop_valid", {31'b0, in_valid}, 32'd0);

        for (int v = 0; v < 3; v++) begin
            begin_burst(vecs[v].fcw, vecs[v].off, vecs[v].num);
            chk("launch_latency", {31'b0, in_valid}, 32'd1);
            chk("launch_theta", {16'b0, theta}, {16'b0, vecs[v].th[0]});
            fcw = 32'h1357_9BDF; phase_offset = 16'h7777; num_samples = 16'd1;
            for (int c = 0; c < 30; c++) cyc();
            chk("vec_xfers", xq.size(), vecs[v].n);
            for (int i = 0; i < vecs[v].n && i < xq.size(); i++)
                chk("vec_theta", {16'b0, xq[i]}, {16'b0, vecs[v].th[i]});
            chk("vec_done_count", ndone, 32'd1);
            chk("vec_sample_idx", {16'b0, sample_idx}, vecs[v].n);
            chk("vec_busy_end", {31'b0, busy}, 32'd0);
        end

        // backpressure: ready low for 5 cycles during ISSUE
        cordic_ready = 1'b0;
        begin_burst(32'h1000_0000, 16'h0000, 16'd2);
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_valid", {31'b0, in_valid}, 32'd1);
            chk("bp_hold_theta", {16'b0, theta}, 32'h0);
            @(negedge clk);
        end
        cordic_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_drop", {31'b0, in_valid}, 32'd0);
        chk("bp_one_xfer", {16'b0, sample_idx}, 32'd1);
        chk("bp_next_theta", {16'b0, theta}, 32'h1000);
        prev_x = 1'b1;
        for (int c = 0; c < 15; c++) cyc();
        chk("bp_done", ndone, 32'd1);
        chk("bp_sample_idx", {16'b0, sample_idx}, 32'd2);

        // stop after the 3rd transfer of a 10-sample burst
        begin_burst(32'h0100_0000, 16'h0000, 16'd10);
        for (int c = 0; c < 40 && xq.size() < 3; c++) cyc();
        chk("stop_pre_xfers", xq.size(), 32'd3);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_valid", {31'b0, in_valid}, 32'd0);
        chk("stop_busy", {31'b0, busy}, 32'd0);
        chk("stop_sample_idx", {16'b0, sample_idx}, 32'd3);
        for (int c = 0; c < 10; c++) cyc();
        chk("stop_no_done", ndone, 32'd0);
        chk("stop_no_more_xfers", xq.size(), 32'd3);

        // continuous mode, with a start while busy that must be ignored
        begin_burst(32'h0001_0000, 16'h0005, 16'd0);
        for (int c = 0; c < 200 && xq.size() < 22; c++) begin
            if (c == 10) begin
                phase_offset = 16'h4444; fcw = 32'h0100_0000; start = 1'b1;
            end
            cyc();
            start = 1'b0;
        end
        chk("cont_xfers", xq.size(), 32'd22);
        for (int i = 0; i < 22 && i < xq.size(); i++)
            chk("cont_theta", {16'b0, xq[i]}, 32'd5 + i);
        chk("cont_busy", {31'b0, busy}, 32'd1);
        stop = 1'b1; cordic_ready = 1'b0;
        @(negedge clk);
        stop = 1'b0;
        chk("cont_stop_busy", {31'b0, busy}, 32'd0);
        chk("cont_stop_valid", {31'b0, in_valid}, 32'd0);
        chk("cont_sample_idx", {16'b0, sample_idx}, xq.size());
        chk("cont_no_done", ndone, 32'd0);

        // asynchronous reset mid-ISSUE
        cordic_ready = 1'b0;
        begin_burst(32'h0300_0000, 16'h0123, 16'd5);
        @(negedge clk);
        #2 rstb = 1'b0;
        #1;
        chk("arst_valid", {31'b0, in_valid}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_theta", {16'b0, theta}, 32'h0);
        @(negedge clk);
        rstb = 1'b1; cordic_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("arst_no_reissue", {31'b0, in_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
